// File: rtl/spi_datapath.sv
// SPI slave data path: oversamples sclk/cs_n/mosi on clk, decodes a 4-bit status,
// 20-bit address and 16 data bits over 1/2/4 lanes, and shifts back rdata on reads.
module spi_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic [3:0]  mosi,
  input  logic [1:0]  spi_mode,
  input  logic [15:0] rdata,
  output logic        address_ready,
  output logic        data_ready,
  output logic [3:0]  miso,
  output logic [19:0] addr,
  output logic [3:0]  status,
  output logic [15:0] wdata,
  output logic        cs_n_o,
  output logic        miso_start
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WDATA,
    RDATA,
    DONE
  } state_t;

  localparam logic [1:0] LANE_SINGLE = 2'b01;
  localparam logic [1:0] LANE_DUAL   = 2'b10;
  localparam logic [1:0] LANE_QUAD   = 2'b11;

  state_t      state;
  logic        sclk_s1, sclk_s2, sclk_d;
  logic        cs_n_s1, cs_n_s2, cs_n_d;
  logic [3:0]  mosi_s1, mosi_s2;
  logic [1:0]  lane_q;
  logic [4:0]  bit_cnt;
  logic [23:0] rx_sr;
  logic [15:0] tx_sr;
  logic        tx_started;

  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [4:0]  step;
  logic [4:0]  cnt_next;
  logic [23:0] rx_next;
  logic [15:0] tx_shift;

  // Top L bits of a word, higher lane carrying the more significant bit.
  function automatic logic [3:0] top_bits(input logic [15:0] v, input logic [1:0] l);
    case (l)
      LANE_QUAD: return v[15:12];
      LANE_DUAL: return {2'b00, v[15:14]};
      default:   return {3'b000, v[15]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_n_s1 <= 1'b1;
      cs_n_s2 <= 1'b1;
      cs_n_d  <= 1'b1;
      mosi_s1 <= '0;
      mosi_s2 <= '0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_n_s1 <= cs_n;
      cs_n_s2 <= cs_n_s1;
      cs_n_d  <= cs_n_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign cs_n_o    = cs_n_s2;
  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cs_fall   = ~cs_n_s2 & cs_n_d;
  assign cs_rise   = cs_n_s2 & ~cs_n_d;

  always_comb begin
    step     = 5'd1;
    rx_next  = {rx_sr[22:0], mosi_s2[0]};
    tx_shift = {tx_sr[14:0], 1'b0};
    case (lane_q)
      LANE_QUAD: begin
        step     = 5'd4;
        rx_next  = {rx_sr[19:0], mosi_s2};
        tx_shift = {tx_sr[11:0], 4'b0000};
      end
      LANE_DUAL: begin
        step     = 5'd2;
        rx_next  = {rx_sr[21:0], mosi_s2[1:0]};
        tx_shift = {tx_sr[13:0], 2'b00};
      end
      default: ;
    endcase
    cnt_next = bit_cnt + step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lane_q        <= LANE_SINGLE;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      tx_started    <= 1'b0;
      address_ready <= 1'b0;
      data_ready    <= 1'b0;
      miso_start    <= 1'b0;
      miso          <= '0;
      addr          <= '0;
      status        <= '0;
      wdata         <= '0;
    end else begin
      address_ready <= 1'b0;
      data_ready    <= 1'b0;
      miso_start    <= 1'b0;
      if (cs_rise) begin
        state <= IDLE;
        miso  <= '0;
      end else begin
        case (state)
          IDLE: begin
            miso <= '0;
            if (cs_fall) begin
              state   <= HEADER;
              bit_cnt <= '0;
              lane_q  <= (spi_mode == 2'b00) ? LANE_SINGLE : spi_mode;
            end
          end
          HEADER: begin
            if (sclk_rise) begin
              rx_sr <= rx_next;
              if (cnt_next == 5'd24) begin
                status        <= rx_next[23:20];
                addr          <= rx_next[19:0];
                address_ready <= 1'b1;
                bit_cnt       <= '0;
                tx_started    <= 1'b0;
                state         <= rx_next[23] ? WDATA : RDATA;
              end else begin
                bit_cnt <= cnt_next;
              end
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              rx_sr <= rx_next;
              if (cnt_next == 5'd16) begin
                wdata      <= rx_next[15:0];
                data_ready <= 1'b1;
                state      <= DONE;
              end else begin
                bit_cnt <= cnt_next;
              end
            end
          end
          RDATA: begin
            // First fall loads rdata directly so its top bits go out without a shift.
            if (sclk_fall) begin
              if (!tx_started) begin
                tx_sr      <= rdata;
                miso       <= top_bits(rdata, lane_q);
                miso_start <= 1'b1;
                tx_started <= 1'b1;
              end else begin
                tx_sr <= tx_shift;
                miso  <= top_bits(tx_shift, lane_q);
              end
            end else if (sclk_rise) begin
              if (cnt_next == 5'd16) begin
                data_ready <= 1'b1;
                miso       <= '0;
                state      <= DONE;
              end else begin
                bit_cnt <= cnt_next;
              end
            end
          end
          DONE: begin
            miso <= '0;
          end
          default: begin
            state <= IDLE;
            miso  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_datapath.sv
// Directed bench for spi_datapath: table of full frames plus abort and mid-frame reset sequences.
module tb_spi_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        cs_n;
  logic [3:0]  mosi;
  logic [1:0]  spi_mode;
  logic [15:0] rdata;
  logic        address_ready;
  logic        data_ready;
  logic [3:0]  miso;
  logic [19:0] addr;
  logic [3:0]  status;
  logic [15:0] wdata;
  logic        cs_n_o;
  logic        miso_start;

  spi_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .spi_mode     (spi_mode),
    .rdata        (rdata),
    .address_ready(address_ready),
    .data_ready   (data_ready),
    .miso         (miso),
    .addr         (addr),
    .status       (status),
    .wdata        (wdata),
    .cs_n_o       (cs_n_o),
    .miso_start   (miso_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int          ar_cnt = 0, dr_cnt = 0, ms_cnt = 0, multi_cnt = 0, miso_nz_cnt = 0;
  logic [19:0] ar_addr = '0;
  logic [3:0]  ar_status = '0;
  logic [15:0] dr_wdata = '0;
  int          ar0, dr0, ms0, multi0, nz0;

  always @(negedge clk) begin
    if (address_ready) begin
      ar_cnt++;
      ar_addr   = addr;
      ar_status = status;
    end
    if (data_ready) begin
      dr_cnt++;
      dr_wdata = wdata;
    end
    if (miso_start) ms_cnt++;
    if (int'(address_ready) + int'(data_ready) + int'(miso_start) > 1) multi_cnt++;
    if (miso != 4'h0) miso_nz_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " address_ready"}, 32'(address_ready), 0);
    check({tag, " data_ready"},    32'(data_ready), 0);
    check({tag, " miso_start"},    32'(miso_start), 0);
    check({tag, " miso"},          32'(miso), 0);
    check({tag, " addr"},          32'(addr), 0);
    check({tag, " status"},        32'(status), 0);
    check({tag, " wdata"},         32'(wdata), 0);
    check({tag, " cs_n_o"},        32'(cs_n_o), 1);
  endtask

  // Drives one frame MSB first; max_edges truncates (abort), reset_edge pulses reset.
  task automatic run_frame(input logic [1:0] mode, input logic [3:0] st, input logic [19:0] ad,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input int max_edges, input int reset_edge);
    int L, mask, hdr_edges, tot;
    logic [39:0] fr;
    logic [3:0]  exp_m;
    L         = (mode == 2'b11) ? 4 : (mode == 2'b10) ? 2 : 1;
    mask      = (1 << L) - 1;
    hdr_edges = 24 / L;
    tot       = 40 / L;
    fr        = {st, ad, wd};
    ar0 = ar_cnt; dr0 = dr_cnt; ms0 = ms_cnt; multi0 = multi_cnt; nz0 = miso_nz_cnt;
    spi_mode = mode;
    rdata    = rd;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_mode = mode ^ 2'b11;
    for (int e = 0; e < tot && e < max_edges; e++) begin
      mosi = 4'((fr >> (40 - L * (e + 1))) & 40'(mask));
      repeat (4) @(negedge clk);
      if (!st[3] && e >= hdr_edges) begin
        exp_m = 4'((rd >> (16 - L * (e - hdr_edges + 1))) & 16'(mask));
        check($sformatf("miso edge %0d", e - hdr_edges), 32'(miso), 32'(exp_m));
      end
      if (e == reset_edge) begin
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        ar0 = ar_cnt; dr0 = dr_cnt; ms0 = ms_cnt;
      end
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    mosi = 4'h0;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  st;
    logic [19:0] ad;
    logic [15:0] wd;
    logic [15:0] rd;
    logic [15:0] exp_wdata;
    int          exp_ms;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{2'b01, 4'h8, 20'h12345, 16'hC69A, 16'h0000, 16'hC69A, 0};
    vecs[1] = '{2'b10, 4'h0, 20'hABCDE, 16'h0000, 16'h8BFA, 16'hC69A, 1};
    vecs[2] = '{2'b11, 4'h0, 20'h55AA3, 16'h0000, 16'hC69A, 16'hC69A, 1};
    vecs[3] = '{2'b11, 4'hF, 20'hFFFFF, 16'h0001, 16'h0000, 16'h0001, 0};
    vecs[4] = '{2'b00, 4'h9, 20'h00001, 16'h8000, 16'h0000, 16'h8000, 0};
    vecs[5] = '{2'b01, 4'h7, 20'h80000, 16'h0000, 16'h1234, 16'h8000, 1};
    vecs[6] = '{2'b10, 4'hA, 20'h0F0F0, 16'h5A5A, 16'h0000, 16'h5A5A, 0};

    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 4'h0; spi_mode = 2'b01; rdata = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_frame(vecs[i].mode, vecs[i].st, vecs[i].ad, vecs[i].wd, vecs[i].rd, 99, -1);
      check($sformatf("v%0d address_ready count", i), 32'(ar_cnt - ar0), 1);
      check($sformatf("v%0d data_ready count", i),    32'(dr_cnt - dr0), 1);
      check($sformatf("v%0d miso_start count", i),    32'(ms_cnt - ms0), 32'(vecs[i].exp_ms));
      check($sformatf("v%0d overlapping pulses", i),  32'(multi_cnt - multi0), 0);
      check($sformatf("v%0d addr at pulse", i),       32'(ar_addr), 32'(vecs[i].ad));
      check($sformatf("v%0d status at pulse", i),     32'(ar_status), 32'(vecs[i].st));
      check($sformatf("v%0d wdata at pulse", i),      32'(dr_wdata), 32'(vecs[i].exp_wdata));
      check($sformatf("v%0d addr held", i),           32'(addr), 32'(vecs[i].ad));
      check($sformatf("v%0d wdata held", i),          32'(wdata), 32'(vecs[i].exp_wdata));
      check($sformatf("v%0d miso idle", i),           32'(miso), 0);
      check($sformatf("v%0d cs_n_o", i),              32'(cs_n_o), 1);
      if (vecs[i].st[3])
        check($sformatf("v%0d miso quiet on write", i), 32'(miso_nz_cnt - nz0), 0);
    end

    // Abort after 10 single-lane bits, then a full frame.
    run_frame(2'b01, 4'h8, 20'h11111, 16'hFFFF, 16'h0000, 10, -1);
    check("abort address_ready count", 32'(ar_cnt - ar0), 0);
    check("abort data_ready count",    32'(dr_cnt - dr0), 0);
    check("abort addr unchanged",      32'(addr), 32'h0F0F0);
    check("abort status unchanged",    32'(status), 32'hA);
    check("abort wdata unchanged",     32'(wdata), 32'h5A5A);
    run_frame(2'b01, 4'h8, 20'h2468A, 16'h1357, 16'h0000, 99, -1);
    check("post-abort address_ready count", 32'(ar_cnt - ar0), 1);
    check("post-abort data_ready count",    32'(dr_cnt - dr0), 1);
    check("post-abort addr",                32'(addr), 32'h2468A);
    check("post-abort wdata",               32'(wdata), 32'h1357);

    // Reset during WDATA (header done, 4 data bits in).
    run_frame(2'b01, 4'h8, 20'h54321, 16'h1111, 16'h0000, 99, 28);
    check("post-reset address_ready count", 32'(ar_cnt - ar0), 0);
    check("post-reset data_ready count",    32'(dr_cnt - dr0), 0);
    check("post-reset addr",                32'(addr), 0);
    check("post-reset status",              32'(status), 0);
    check("post-reset wdata",               32'(wdata), 0);

    run_frame(2'b11, 4'h2, 20'hC0DE5, 16'h0000, 16'hBEEF, 99, -1);
    check("recover miso_start count", 32'(ms_cnt - ms0), 1);
    check("recover data_ready count", 32'(dr_cnt - dr0), 1);
    check("recover addr",             32'(addr), 32'hC0DE5);
    check("recover status",           32'(status), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
